// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types and constants for the hex keypad scanner: FSM states,
// idle/reset vectors and the active-low one-hot decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // {valid, index}: index 0 means bit 3 is the single low bit, 3 means bit 0.
    function automatic logic [2:0] onehot_low_idx(input logic [3:0] v);
        logic [2:0] res;
        case (v)
            4'b0111: res = 3'b100;
            4'b1011: res = 3'b101;
            4'b1101: res = 3'b110;
            4'b1110: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Resets to the idle (all released) pattern.
module row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_rs
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= ROWS_IDLE;
            r_sync <= ROWS_IDLE;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_rs = r_sync;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobe, press/release debounce, key strobe.
// Define KEYPAD_DIGITS_EN to build the 16-bit last-four-keys shift register.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic [15:0] digits
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_W-1:0] r_div;
    logic [3:0]            r_col;
    logic [1:0]            r_cidx;
    logic [1:0]            r_cand;
    logic [3:0]            r_cnt;
    logic [3:0]            r_key;
    logic                  r_key_valid;
    state_t                r_state;

    logic [3:0] w_rs;
    logic [2:0] w_row_hit;
    logic       w_tick;
    logic       w_match;
    logic       w_load;
    logic [3:0] w_col_rot;
    logic [3:0] w_new_key;

    row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .i_row (row),
        .o_rs  (w_rs)
    );

    assign w_tick    = &r_div;
    assign w_row_hit = onehot_low_idx(w_rs);
    assign w_match   = w_row_hit[2] && (w_row_hit[1:0] == r_cand);
    assign w_load    = w_tick && (r_state == DEBOUNCE) && w_match && (r_cnt + 4'd1 == DB_N);
    assign w_col_rot = {r_col[0], r_col[3:1]};
    assign w_new_key = {r_cand, r_cidx};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_col       <= COL_RESET;
            r_cidx      <= 2'd0;
            r_cand      <= 2'd0;
            r_cnt       <= 4'd0;
            r_key       <= 4'd0;
            r_key_valid <= 1'b0;
            r_state     <= SCAN;
        end else begin
            r_div       <= r_div + SCAN_DIV_W'(1);
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_row_hit[2]) begin
                            r_cand  <= w_row_hit[1:0];
                            r_cnt   <= 4'd1;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col  <= w_col_rot;
                            r_cidx <= r_cidx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_load) begin
                            r_key       <= w_new_key;
                            r_key_valid <= 1'b1;
                            r_cnt       <= 4'd0;
                            r_state     <= HELD;
                        end else if (w_match) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            // Lost the candidate: abandon it and move on to the next column.
                            r_cnt   <= 4'd0;
                            r_state <= SCAN;
                            r_col   <= w_col_rot;
                            r_cidx  <= r_cidx + 2'd1;
                        end
                    end
                    HELD: begin
                        if (w_rs == ROWS_IDLE) begin
                            if (r_cnt + 4'd1 == DB_N) begin
                                r_cnt   <= 4'd0;
                                r_state <= SCAN;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_cnt   <= 4'd0;
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;

`ifdef KEYPAD_DIGITS_EN
    logic [15:0] r_digits;

    // Loads on the same edge as key so digits and key_valid line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= 16'h0000;
        end else if (w_load) begin
            r_digits <= {r_digits[11:0], w_new_key};
        end
    end

    assign digits = r_digits;
`else
    assign digits = 16'h0000;
`endif

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Randomised bench for hex_keypad_scanner against a tick-level keypad model,
// with a physical keypad model that pulls rows low from the pressed-key set.
module tb_hex_keypad_scanner;

    localparam int W    = 4;
    localparam int N    = 3;
    localparam int TICK = 1 << W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row = 4'hF;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic [15:0] digits;

    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;
    int n_pulse = 0;
    int n_colchg = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hex_keypad_scanner #(.SCAN_DIV_W(W), .DEBOUNCE_SCANS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .digits    (digits)
    );

    // Key k sits at row k/4, column k%4; a pressed key shorts its row to its column.
    function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] cl);
        logic [3:0] rr;
        rr = 4'hF;
        for (int k = 0; k < 16; k++)
            if (p[k] && cl[3 - (k % 4)] == 1'b0) rr[3 - (k / 4)] = 1'b0;
        return rr;
    endfunction

    always @(negedge clk) row = rows_for(pressed, col);

    function automatic int single_low(input logic [3:0] v);
        int zeros;
        int r;
        zeros = 0;
        r = -1;
        for (int b = 0; b < 4; b++)
            if (v[b] == 1'b0) begin
                zeros++;
                r = 3 - b;
            end
        return (zeros == 1) ? r : -1;
    endfunction

    // Reference model: tick-level behaviour of the keypad scanner.
    int          m_div, m_c, m_streak, m_idle, m_cand, m_s;
    logic [3:0]  m_s1, m_s2, m_rs, m_key;
    logic        m_kv;
    logic [15:0] m_digits;
    bit          m_locked, m_tick;

    always @(posedge clk) begin
        if (rst) begin
            m_div = 0; m_c = 0; m_streak = 0; m_idle = 0; m_cand = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'h0; m_kv = 1'b0;
            m_digits = 16'h0; m_locked = 1'b0;
        end else begin
            m_tick = (m_div == TICK - 1);
            m_rs   = m_s2;
            m_div  = (m_div + 1) % TICK;
            m_s2   = m_s1;
            m_s1   = row;
            m_kv   = 1'b0;
            if (m_tick) begin
                m_s = single_low(m_rs);
                if (m_locked) begin
                    m_idle = (m_rs == 4'hF) ? m_idle + 1 : 0;
                    if (m_idle == N) begin
                        m_locked = 1'b0;
                        m_idle = 0;
                    end
                end else if (m_streak == 0) begin
                    if (m_s >= 0) begin
                        m_cand = m_s;
                        m_streak = 1;
                    end else m_c = (m_c + 1) % 4;
                end else if (m_s == m_cand) begin
                    m_streak++;
                    if (m_streak == N) begin
                        m_locked = 1'b1;
                        m_streak = 0;
                        m_idle = 0;
                        m_key = 4'(4 * m_cand + m_c);
                        m_kv = 1'b1;
`ifdef KEYPAD_DIGITS_EN
                        m_digits = {m_digits[11:0], m_key};
`endif
                    end
                end else begin
                    m_streak = 0;
                    m_c = (m_c + 1) % 4;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [3:0] prev_col = 4'b0111;
    always @(negedge clk) begin
        if (key_valid === 1'b1) n_pulse++;
        if (col !== prev_col) n_colchg++;
        prev_col = col;
        if (cmp_en) begin
            check("col", {12'h0, col}, {12'h0, ~(4'b1000 >> m_c)});
            check("key", {12'h0, key}, {12'h0, m_key});
            check("key_valid", {15'h0, key_valid}, {15'h0, m_kv});
            check("digits", digits, m_digits);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * TICK) @(posedge clk);
        #2;
    endtask

    task automatic press(input int k, input int hold, input int rel);
        pressed = 16'h0001 << k;
        wait_ticks(hold);
        pressed = 16'h0;
        wait_ticks(rel);
    endtask

    function automatic logic [15:0] dexp(input logic [15:0] v);
`ifdef KEYPAD_DIGITS_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, cyc, last, guard;
        logic [3:0] seq [4];
        logic [3:0] old;
        logic [15:0] dseq [5];
        int keys [5];
        seq  = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
        keys = '{1, 2, 10, 15, 3};
        dseq = '{16'h0001, 16'h0012, 16'h012A, 16'h12AF, 16'h2AF3};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", {12'h0, col}, 16'h0007);
        check("rst_key", {12'h0, key}, 16'h0000);
        check("rst_kv", {15'h0, key_valid}, 16'h0000);
        check("rst_digits", digits, 16'h0000);
        cmp_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;

        // Column rotation order and period after reset
        cyc = 0; last = 0;
        for (int i = 0; i < 4; i++) begin
            old = col;
            guard = 0;
            while (col === old && guard < 40) begin
                @(posedge clk); #1; cyc++; guard++;
            end
            check("rot_timeout", 16'(guard < 40), 16'h1);
            check("rot_value", {12'h0, col}, {12'h0, seq[i]});
            check("rot_period", 16'(cyc - last), 16'(TICK));
            last = cyc;
        end
        #1;

        // Single press of key 9 (row 2, column 1)
        p0 = n_pulse;
        pressed = 16'h0001 << 9;
        wait_ticks(10);
        check("single_pulses", 16'(n_pulse - p0), 16'h1);
        check("single_key", {12'h0, key}, 16'h0009);
        check("single_col_held", {12'h0, col}, 16'h000B);
        check("single_digits", digits, dexp(16'h0009));
        pressed = 16'h0;
        wait_ticks(6);

        // Bounce rejection
        p0 = n_pulse;
        pressed = 16'h0001 << 9;
        wait_ticks(2);
        pressed = 16'h0;
        wait_ticks(1);
        check("bounce_none", 16'(n_pulse - p0), 16'h0);
        pressed = 16'h0001 << 9;
        wait_ticks(8);
        check("bounce_one", 16'(n_pulse - p0), 16'h1);
        check("bounce_key", {12'h0, key}, 16'h0009);
        pressed = 16'h0;
        wait_ticks(6);

        // Sequence from a fresh reset
        rst = 1'b1;
        wait_ticks(0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            press(keys[i], 8, 6);
            check("seq_key", {12'h0, key}, 16'(keys[i]));
            check("seq_digits", digits, dexp(dseq[i]));
        end

        // Multi-key on one column: ignored, scanning continues
        p0 = n_pulse;
        n_colchg = 0;
        pressed = (16'h0001 << 1) | (16'h0001 << 5);
        wait_ticks(12);
        check("multi_none", 16'(n_pulse - p0), 16'h0);
        check("multi_scanning", 16'(n_colchg >= 11), 16'h1);
        pressed = 16'h0;
        wait_ticks(2);

        // Reset after two matching samples
        p0 = n_pulse;
        pressed = 16'h0001 << 6;
        guard = 0;
        while (m_streak != 2 && guard < 400) begin
            @(posedge clk); guard++;
        end
        #2;
        check("middb_reached", 16'(guard < 400), 16'h1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("middb_none", 16'(n_pulse - p0), 16'h0);
        check("middb_col", {12'h0, col}, 16'h0007);
        check("middb_key", {12'h0, key}, 16'h0000);
        check("middb_digits", digits, 16'h0000);
        pressed = 16'h0;
        @(posedge clk); #2;
        rst = 1'b0;

        // Random presses, multi-presses and gaps
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: pressed = 16'h0;
                1, 2: pressed = 16'h0001 << $urandom_range(0, 15);
                default: pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            wait_ticks($urandom_range(1, 8));
        end
        pressed = 16'h0;
        wait_ticks(6);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
